sca_conv_multich_acc: RTL

//  Parametrised sparse-Winograd conv core: per accepted 4x4 transform-domain input tile,

---
 rtl/sca_conv_pkg.sv | 24 ++
 rtl/sca_sparse_lane.sv | 55 +++++
 rtl/sca_conv_multich_acc.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sca_conv_pkg.sv
// Shared constants and the accumulator clamp/wrap helper for the sparse-Winograd conv core.
package sca_conv_pkg;

  localparam int TILE_ELEMS = 16;
  localparam int IDX_W      = 4;
  // Per-position sum width for the default ACC_W=32, NNZ=6 configuration.
  localparam int SUM_W      = 32 + $clog2(6) + 1;

  // Returns the value to store for a wide sum; the caller keeps the low acc_w bits,
  // which is the two's-complement wrap when not saturating.
  function automatic logic signed [63:0] sat_acc(input  logic signed [63:0] sum,
                                                 input  int                 acc_w,
                                                 input  bit                 saturate,
                                                 output logic               ovf);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    max_v = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (acc_w - 1));
    ovf   = (sum > max_v) || (sum < min_v);
    if (ovf && saturate) sat_acc = (sum > max_v) ? max_v : min_v;
    else                 sat_acc = sum;
  endfunction

endpackage

// File: rtl/sca_sparse_lane.sv
// One output channel: gathers tile elements into NNZ products (pre-S1) and folds the
// registered products into 16 per-position sums (post-S1). Purely combinational.
module sca_sparse_lane
  import sca_conv_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NNZ    = 6,
  parameter int PSUM_W = sca_conv_pkg::SUM_W
) (
  input  logic [TILE_ELEMS*DATA_W-1:0] tile_i,
  input  logic [NNZ*DATA_W-1:0]        w_i,
  input  logic [NNZ*IDX_W-1:0]         idx_i,
  output logic [NNZ*2*DATA_W-1:0]      prod_o,
  input  logic [NNZ*2*DATA_W-1:0]      prod_q_i,
  input  logic [NNZ*IDX_W-1:0]         idx_q_i,
  output logic [TILE_ELEMS*PSUM_W-1:0] psum_o
);

  localparam int PW = 2 * DATA_W;

  always_comb begin : products
    logic signed [DATA_W-1:0] w_s;
    logic signed [DATA_W-1:0] y_s;
    logic signed [PW-1:0]     p_s;
    // NOTE: every variable written in a combinational block gets a default first, so no latch is inferred.
    prod_o = '0;
    w_s    = '0;
    y_s    = '0;
    p_s    = '0;
    for (int k = 0; k < NNZ; k++) begin
      w_s = $signed(w_i[k*DATA_W +: DATA_W]);
      y_s = $signed(tile_i[idx_i[k*IDX_W +: IDX_W]*DATA_W +: DATA_W]);
      p_s = PW'(w_s) * PW'(y_s);
      prod_o[k*PW +: PW] = p_s;
    end
  end

  // Duplicate indices simply add into the same position.
  always_comb begin : position_sums
    logic signed [PSUM_W-1:0] acc_v;
    logic signed [PW-1:0]     p_s;
    psum_o = '0;
    acc_v  = '0;
    p_s    = '0;
    for (int e = 0; e < TILE_ELEMS; e++) begin
      acc_v = '0;
      for (int k = 0; k < NNZ; k++) begin
        p_s = $signed(prod_q_i[k*PW +: PW]);
        if (idx_q_i[k*IDX_W +: IDX_W] == IDX_W'(e)) acc_v = acc_v + PSUM_W'(p_s);
      end
      psum_o[e*PSUM_W +: PSUM_W] = acc_v;
    end
  end

endmodule

// File: rtl/sca_conv_multich_acc.sv
// Multi-channel sparse-Winograd accumulator: S1 registers products, S2 accumulates
// across a group's beats and loads a one-deep result buffer on the group's last beat.
module sca_conv_multich_acc
  import sca_conv_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int NUM_OCH  = 3,
  parameter int NNZ      = 6,
  parameter int MAX_ICH  = 256,
  parameter int SATURATE = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [TILE_ELEMS*DATA_W-1:0]        in_tile,
  input  logic [NUM_OCH*NNZ*DATA_W-1:0]       in_w,
  input  logic [NUM_OCH*NNZ*IDX_W-1:0]        in_idx,
  input  logic                                in_last,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [NUM_OCH*TILE_ELEMS*ACC_W-1:0] out_u,
  output logic [NUM_OCH-1:0]                  out_ovf,
  output logic [$clog2(MAX_ICH+1)-1:0]        out_nbeats
);

  localparam int PW     = 2 * DATA_W;
  localparam int SW     = ACC_W + $clog2(NNZ) + 1;
  localparam int CNT_W  = $clog2(MAX_ICH + 1);
  localparam int LANE_P = NNZ * PW;
  localparam int LANE_I = NNZ * IDX_W;
  localparam int TILE_A = TILE_ELEMS * ACC_W;

  logic                         s1_valid_q, s1_last_q, s1_first_q, first_q;
  logic [NUM_OCH*LANE_P-1:0]    s1_prod_q;
  logic [NUM_OCH*LANE_I-1:0]    s1_idx_q;
  logic [NUM_OCH*TILE_A-1:0]    acc_q, acc_d;
  logic [NUM_OCH-1:0]           ovf_q, ovf_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d, cnt_base;
  logic                         out_valid_q;
  logic [NUM_OCH*TILE_A-1:0]    out_u_q;
  logic [NUM_OCH-1:0]           out_ovf_q;
  logic [CNT_W-1:0]             out_nbeats_q;

  logic [NUM_OCH*LANE_P-1:0]          prod_w;
  logic [NUM_OCH*TILE_ELEMS*SW-1:0]   psum_w;
  logic                               stall, accept, s2_fire;

  for (genvar o = 0; o < NUM_OCH; o++) begin : g_lane
    sca_sparse_lane #(
      .DATA_W (DATA_W),
      .NNZ    (NNZ),
      .PSUM_W (SW)
    ) u_lane (
      .tile_i   (in_tile),
      .w_i      (in_w[o*NNZ*DATA_W +: NNZ*DATA_W]),
      .idx_i    (in_idx[o*LANE_I +: LANE_I]),
      .prod_o   (prod_w[o*LANE_P +: LANE_P]),
      .prod_q_i (s1_prod_q[o*LANE_P +: LANE_P]),
      .idx_q_i  (s1_idx_q[o*LANE_I +: LANE_I]),
      .psum_o   (psum_w[o*TILE_ELEMS*SW +: TILE_ELEMS*SW])
    );
  end

  // A closing beat may only leave S1 when the result buffer is free or draining now.
  assign stall    = s1_valid_q & s1_last_q & out_valid_q & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign s2_fire  = s1_valid_q & ~stall;

  always_comb begin
    logic signed [SW-1:0] base_v;
    logic signed [SW-1:0] sum_v;
    logic                 of_v;
    acc_d  = '0;
    ovf_d  = s1_first_q ? '0 : ovf_q;
    base_v = '0;
    sum_v  = '0;
    of_v   = 1'b0;
    for (int o = 0; o < NUM_OCH; o++) begin
      for (int e = 0; e < TILE_ELEMS; e++) begin
        base_v = s1_first_q ? '0 : SW'($signed(acc_q[(o*TILE_ELEMS+e)*ACC_W +: ACC_W]));
        sum_v  = base_v + $signed(psum_w[(o*TILE_ELEMS+e)*SW +: SW]);
        acc_d[(o*TILE_ELEMS+e)*ACC_W +: ACC_W] =
          ACC_W'(sat_acc(64'(sum_v), ACC_W, SATURATE != 0, of_v));
        ovf_d[o] = ovf_d[o] | of_v;
      end
    end
    cnt_base = s1_first_q ? '0 : cnt_q;
    cnt_d    = (cnt_base == CNT_W'(MAX_ICH)) ? cnt_base : cnt_base + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_first_q   <= 1'b1;
      s1_prod_q    <= '0;
      s1_idx_q     <= '0;
      first_q      <= 1'b1;
      // NOTE: the accumulator array is reset explicitly so a reset mid-group discards partial sums.
      acc_q        <= '0;
      ovf_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_u_q      <= '0;
      out_ovf_q    <= '0;
      out_nbeats_q <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_q <= in_valid;
        if (accept) begin
          s1_prod_q  <= prod_w;
          s1_idx_q   <= in_idx;
          s1_last_q  <= in_last;
          s1_first_q <= first_q;
          first_q    <= in_last;
        end
      end
      if (s2_fire) begin
        acc_q <= acc_d;
        if (s1_last_q) begin
          ovf_q        <= '0;
          cnt_q        <= '0;
          out_u_q      <= acc_d;
          out_ovf_q    <= ovf_d;
          out_nbeats_q <= cnt_d;
        end else begin
          ovf_q <= ovf_d;
          cnt_q <= cnt_d;
        end
      end
      if (s2_fire && s1_last_q)          out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready) out_valid_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_u      = out_u_q;
  assign out_ovf    = out_ovf_q;
  assign out_nbeats = out_nbeats_q;

endmodule
